// File: rtl/morph_pkg.sv
// ---------------------------------------------------------------------------
// morph_pkg
// Shared definitions for the morphological program executor:
//   - instruction field positions inside one opcode word
//   - morphological operation codes
//   - executor FSM state encoding
// ---------------------------------------------------------------------------
package morph_pkg;

    // Instruction word layout: [15:14] op, [13:9] reserved, [8:0] 3x3 SE
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 14;
    localparam int SE_MSB  = 8;
    localparam int SE_BITS = SE_MSB + 1;

    typedef enum logic [1:0] {
        MORPH_NOP        = 2'b00,
        MORPH_ERODE      = 2'b01,
        MORPH_DILATE     = 2'b10,
        MORPH_COMPLEMENT = 2'b11
    } morph_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_COUNT = 2'b10,
        ST_DONE  = 2'b11
    } exec_state_e;

endpackage

// File: rtl/morph_image_op.sv
// ---------------------------------------------------------------------------
// morph_image_op
// Combinational application of one morphological instruction to a whole
// binary image. Pixel (r,c) lives at bit (H-1-r)*W + (W-1-c).
// Ports:
//   instr_i  OpcodeWidth  instruction word (op, reserved, 3x3 SE)
//   img_i    W*H          input image
//   img_o    W*H          image after the instruction
// ---------------------------------------------------------------------------
module morph_image_op
    import morph_pkg::*;
#(
    parameter int ImageWidth  = 32,
    parameter int ImageHeight = 16,
    parameter int OpcodeWidth = 16
) (
    input  logic [OpcodeWidth-1:0]             instr_i,
    input  logic [ImageWidth*ImageHeight-1:0]  img_i,
    output logic [ImageWidth*ImageHeight-1:0]  img_o
);

    morph_op_e          op_s;
    logic [SE_MSB:0]    se_s;
    logic               unused_reserved_s;

    assign op_s = morph_op_e'(instr_i[OP_MSB:OP_LSB]);
    assign se_s = instr_i[SE_MSB:0];
    // Reserved field has no effect on the result
    assign unused_reserved_s = ^instr_i[OP_LSB-1:SE_MSB+1];

    for (genvar r = 0; r < ImageHeight; r++) begin : g_row
        for (genvar c = 0; c < ImageWidth; c++) begin : g_col
            localparam int P = (ImageHeight-1-r)*ImageWidth + (ImageWidth-1-c);
            logic [SE_MSB:0] nb_s;
            logic            pix_s;

            // Neighbourhood gather; SE bit k maps to offset (k/3-1, k%3-1),
            // neighbours outside the image are tied to zero at elaboration
            for (genvar k = 0; k < SE_BITS; k++) begin : g_nb
                localparam int NR = r + (k / 3) - 1;
                localparam int NC = c + (k % 3) - 1;
                if (NR >= 0 && NR < ImageHeight && NC >= 0 && NC < ImageWidth) begin : g_in
                    assign nb_s[k] = img_i[(ImageHeight-1-NR)*ImageWidth + (ImageWidth-1-NC)];
                end else begin : g_out
                    assign nb_s[k] = 1'b0;
                end
            end

            // Per-pixel operation select; unselected SE bits are neutral
            // for AND (forced to 1) and OR (forced to 0)
            always_comb begin
                pix_s = img_i[P];
                case (op_s)
                    MORPH_NOP:        pix_s = img_i[P];
                    MORPH_ERODE:      pix_s = &(nb_s | ~se_s);
                    MORPH_DILATE:     pix_s = |(nb_s & se_s);
                    MORPH_COMPLEMENT: pix_s = ~img_i[P];
                    default:          pix_s = img_i[P];
                endcase
            end

            assign img_o[P] = pix_s;
        end
    end

endmodule

// File: rtl/morph_program_executor.sv
// ---------------------------------------------------------------------------
// morph_program_executor
// Runs one GA individual (N morphological instructions) on an origin image,
// then counts pixels differing from the objective image, one row per cycle.
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active-low
//   start       run request, sampled only in IDLE
//   individual  program; instr i = bits [i*OpcodeWidth +: OpcodeWidth]
//   origin      source image
//   objetive    target image
//   busy        high while a run is executing/counting
//   done        one-cycle completion pulse
//   result      image after the last instruction (held until next done)
//   error       popcount(result ^ objetive) (held until next done)
// ---------------------------------------------------------------------------
module morph_program_executor
    import morph_pkg::*;
#(
    parameter int ImageWidth       = 32,
    parameter int ImageHeight      = 16,
    parameter int ErrorWidth       = $clog2(ImageWidth*ImageHeight+1),
    parameter int OpcodeWidth      = 16,
    parameter int OpCounterWidth   = 2,
    parameter int InstructionWidth = OpcodeWidth*(2**OpCounterWidth)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [InstructionWidth-1:0]        individual,
    input  logic [ImageWidth*ImageHeight-1:0]  origin,
    input  logic [ImageWidth*ImageHeight-1:0]  objetive,
    output logic                               busy,
    output logic                               done,
    output logic [ImageWidth*ImageHeight-1:0]  result,
    output logic [ErrorWidth-1:0]              error
);

    localparam int PixCount = ImageWidth*ImageHeight;
    localparam int RowWidth = (ImageHeight > 1) ? $clog2(ImageHeight) : 1;
    localparam logic [OpCounterWidth-1:0] IDX_LAST = {OpCounterWidth{1'b1}};
    localparam logic [RowWidth-1:0]       ROW_LAST = RowWidth'(ImageHeight-1);

    exec_state_e                  state_q;
    logic [InstructionWidth-1:0]  indiv_q;
    logic [PixCount-1:0]          img_q;
    logic [PixCount-1:0]          obj_q;
    logic [PixCount-1:0]          img_d;
    logic [PixCount-1:0]          result_q;
    logic [PixCount-1:0]          diff_s;
    logic [OpCounterWidth-1:0]    idx_q;
    logic [RowWidth-1:0]          row_q;
    logic [ErrorWidth-1:0]        acc_q;
    logic [ErrorWidth-1:0]        error_q;
    logic [ErrorWidth-1:0]        row_pop_s;
    logic [ImageWidth-1:0]        row_bits_s;
    logic [OpcodeWidth-1:0]       instr_s;
    logic                         busy_q;
    logic                         done_q;

    function automatic logic [ErrorWidth-1:0] row_popcount(input logic [ImageWidth-1:0] bits);
        logic [ErrorWidth-1:0] cnt;
        cnt = {ErrorWidth{1'b0}};
        for (int i = 0; i < ImageWidth; i++) begin
            cnt = cnt + ErrorWidth'(bits[i]);
        end
        return cnt;
    endfunction

    // Current instruction selected from the latched individual
    always_comb begin
        instr_s = indiv_q[idx_q*OpcodeWidth +: OpcodeWidth];
    end

    morph_image_op #(
        .ImageWidth  (ImageWidth),
        .ImageHeight (ImageHeight),
        .OpcodeWidth (OpcodeWidth)
    ) u_image_op (
        .instr_i (instr_s),
        .img_i   (img_q),
        .img_o   (img_d)
    );

    // Mismatch count of the current row; row 0 sits at the MSB end
    always_comb begin
        diff_s     = img_q ^ obj_q;
        row_bits_s = diff_s[(ImageHeight-1-int'(row_q))*ImageWidth +: ImageWidth];
        row_pop_s  = row_popcount(row_bits_s);
    end

    // Executor FSM with working and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            indiv_q  <= {InstructionWidth{1'b0}};
            img_q    <= {PixCount{1'b0}};
            obj_q    <= {PixCount{1'b0}};
            result_q <= {PixCount{1'b0}};
            idx_q    <= {OpCounterWidth{1'b0}};
            row_q    <= {RowWidth{1'b0}};
            acc_q    <= {ErrorWidth{1'b0}};
            error_q  <= {ErrorWidth{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        indiv_q <= individual;
                        img_q   <= origin;
                        obj_q   <= objetive;
                        idx_q   <= {OpCounterWidth{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    img_q <= img_d;
                    idx_q <= idx_q + OpCounterWidth'(1);
                    if (idx_q == IDX_LAST) begin
                        acc_q   <= {ErrorWidth{1'b0}};
                        row_q   <= {RowWidth{1'b0}};
                        state_q <= ST_COUNT;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_COUNT: begin
                    acc_q <= acc_q + row_pop_s;
                    row_q <= row_q + RowWidth'(1);
                    if (row_q == ROW_LAST) begin
                        result_q <= img_q;
                        error_q  <= acc_q + row_pop_s;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_DONE;
                    end else begin
                        state_q <= ST_COUNT;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign error  = error_q;

endmodule
